tile_lane_ctrl: RTL and testbench
=================================

// Module: tile_lane_ctrl
// PURPOSE
//  Motion/hit controller for one falling piano tile in one lane. Steps the tile
//  down once per video frame and judges the lane key as hit or miss.
//  Produces the per-pixel ObjectOn consumed by the box renderer, plus hit/miss
//  pulses for the score/game FSM. One instance per lane; shares the VGA DrawX/DrawY.
// PARAMETERS
//  LANE_X        10'd0    left edge of lane, pixels
//  TILE_W        10'd100  tile width, pixels
//  TILE_H        10'd100  tile height, pixels
//  SCREEN_H      11'd480  visible lines
//  HIT_TOP       11'd380  tile bottom must be >= this for a press to count as a hit
//  SPEED         4'd2     pixels moved per frame
//  FLASH_FRAMES  4'd8     frames the tile stays drawn after a hit
// PORTS
//  Clk        in   1   system clock
//  Reset      in   1   synchronous, active-high
//  frame_clk  in   1   VGA vsync-rate level; rising edge detected internally = frame tick
//  start      in   1   launch a new tile (honoured only in IDLE)
//  key_press  in   1   lane key level; rising edge detected internally
//  DrawX      in   10  current pixel column
//  DrawY      in   10  current pixel row
//  ObjectOn   out  1   pixel (DrawX,DrawY) lies on the tile (combinational from registered state)
//  TileBottom out  11  row one past tile's last line; tile occupies [TileBottom-TILE_H, TileBottom)
//  hit        out  1   one-Clk pulse on successful press
//  miss       out  1   one-Clk pulse on early press or tile escaping
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  - Edge detect: frame_prev/key_prev flops; tick = frame_clk & ~frame_prev,
//    kedge = key_press & ~key_prev. Both flops reset to 0.
//  - Reset: state=IDLE, TileBottom=0, flash_cnt=0, hit=0, miss=0, busy=0. Reset
//    mid-fall aborts the tile immediately, with no miss pulse.
//  - States:
//    IDLE: start -> FALL, TileBottom=0.
//    FALL: on tick, TileBottom += SPEED (11-bit unsigned; max 480+100+15 < 2048, no wrap).
//      kedge & TileBottom >= HIT_TOP -> hit=1, flash_cnt=FLASH_FRAMES, FLASH.
//      kedge & TileBottom <  HIT_TOP -> miss=1, IDLE.
//      TileBottom > SCREEN_H + TILE_H - 1 (fully off-screen) -> miss=1, IDLE.
//    FLASH: position frozen. On each tick, flash_cnt--. Tick with flash_cnt==1 -> IDLE, TileBottom=0.
//  - Simultaneous kedge and tick in FALL: judge the key against the pre-update
//    TileBottom. On hit or miss, the move is not applied.
//  - Escape check uses the registered TileBottom; it fires the cycle after the move that crosses the limit.
//  - Key edges in IDLE/FLASH and start outside IDLE are ignored. start & kedge in IDLE: start wins, key ignored.
//  - ObjectOn = busy & DrawX in [LANE_X, LANE_X+TILE_W) & {1'b0,DrawY} in
//    [TileBottom-TILE_H, TileBottom). Compare at 11 bits so a partially entered tile
//    (TileBottom < TILE_H) shows only rows 0..TileBottom-1. Zero latency: box is combinational.
//  - hit/miss are registered, exactly one cycle wide, never both high.
// TESTING
//  1 Reset held 3 cycles mid-FALL -> ObjectOn=0, TileBottom=0, busy=0, no miss pulse.
//  2 start, 40 ticks (SPEED=2) -> TileBottom=80. DrawX=LANE_X, DrawY=79 -> ObjectOn=1.
//    DrawY=80 -> 0. DrawX=LANE_X+100 -> 0.
//  3 Fall to TileBottom=380, key edge -> hit pulse 1 cycle, 8 ticks FLASH with TileBottom
//    fixed at 380, then IDLE, busy=0.
//  4 Key edge at TileBottom=378 -> miss pulse, IDLE. Key edge in IDLE -> no pulse.
//  5 No key press -> miss when TileBottom reaches 580, IDLE next cycle. ObjectOn=0 for every DrawY at TileBottom=580.
//  6 Key edge and tick in same cycle at TileBottom=378 -> miss, TileBottom stays 378.
//    At TileBottom=380 -> hit, TileBottom stays 380.

Source files
------------

// File: rtl/tile_lane_ctrl.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
//  Module   : tile_lane_ctrl
//  Purpose  : Motion and hit controller for one falling piano tile in one
//             lane. Steps the tile once per video frame, judges the lane key,
//             and draws the tile box for the shared VGA DrawX/DrawY scan.
//  Revision : 1.0  initial release
// ============================================================================
module tile_lane_ctrl #(
   parameter logic [9:0]  LANE_X       = 10'd0,
   parameter logic [9:0]  TILE_W       = 10'd100,
   parameter logic [9:0]  TILE_H       = 10'd100,
   parameter logic [10:0] SCREEN_H     = 11'd480,
   parameter logic [10:0] HIT_TOP      = 11'd380,
   parameter logic [3:0]  SPEED        = 4'd2,
   parameter logic [3:0]  FLASH_FRAMES = 4'd8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        start,
   input  logic        key_press,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic        ObjectOn,
   output logic [10:0] TileBottom,
   output logic        hit,
   output logic        miss,
   output logic        busy
);

   // Last TileBottom value at which some row of the tile is still on screen.
   localparam logic [10:0] ESCAPE_LIM = SCREEN_H + {1'b0, TILE_H} - 11'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FALL  = 2'd1,
      FLASH = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [10:0] tile_bottom_q, tile_bottom_d;
   logic [3:0]  flash_cnt_q, flash_cnt_d;
   logic        hit_q, hit_d;
   logic        miss_q, miss_d;
   logic        frame_prev_q;
   logic        key_prev_q;

   logic        w_tick;
   logic        w_kedge;
   logic [10:0] w_x_off;
   logic        w_x_in;
   logic [11:0] w_y_ext;
   logic [11:0] w_y_top_ext;
   logic [11:0] w_bottom_ext;
   logic        w_y_in;

   assign w_tick  = frame_clk & ~frame_prev_q;
   assign w_kedge = key_press & ~key_prev_q;

   // Edge-detect history for the frame strobe and the lane key.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_prev_q <= 1'b0;
         key_prev_q   <= 1'b0;
      end else begin
         frame_prev_q <= frame_clk;
         key_prev_q   <= key_press;
      end
   end

   // Next-state logic: key judgement takes priority over escape and motion,
   // so a key edge coinciding with a tick is judged on the pre-move position.
   always_comb begin
      state_d       = state_q;
      tile_bottom_d = tile_bottom_q;
      flash_cnt_d   = flash_cnt_q;
      hit_d         = 1'b0;
      miss_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d       = FALL;
               tile_bottom_d = 11'd0;
            end
         end
         FALL: begin
            if (w_kedge) begin
               if (tile_bottom_q >= HIT_TOP) begin
                  hit_d       = 1'b1;
                  flash_cnt_d = FLASH_FRAMES;
                  state_d     = FLASH;
               end else begin
                  miss_d  = 1'b1;
                  state_d = IDLE;
               end
            end else if (tile_bottom_q > ESCAPE_LIM) begin
               miss_d  = 1'b1;
               state_d = IDLE;
            end else if (w_tick) begin
               tile_bottom_d = tile_bottom_q + {7'd0, SPEED};
            end
         end
         FLASH: begin
            if (w_tick) begin
               if (flash_cnt_q <= 4'd1) begin
                  flash_cnt_d   = 4'd0;
                  tile_bottom_d = 11'd0;
                  state_d       = IDLE;
               end else begin
                  flash_cnt_d = flash_cnt_q - 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, position and pulse registers; reset aborts any tile silently.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= IDLE;
         tile_bottom_q <= 11'd0;
         flash_cnt_q   <= 4'd0;
         hit_q         <= 1'b0;
         miss_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         tile_bottom_q <= tile_bottom_d;
         flash_cnt_q   <= flash_cnt_d;
         hit_q         <= hit_d;
         miss_q        <= miss_d;
      end
   end

   // Column test: offset wraps large when DrawX is left of the lane.
   assign w_x_off = {1'b0, DrawX} - {1'b0, LANE_X};
   assign w_x_in  = (w_x_off < {1'b0, TILE_W});

   // Row test done as y + TILE_H >= bottom so a partially entered tile never
   // underflows its top edge.
   assign w_y_ext      = {2'b00, DrawY};
   assign w_y_top_ext  = w_y_ext + {2'b00, TILE_H};
   assign w_bottom_ext = {1'b0, tile_bottom_q};
   assign w_y_in       = (w_y_top_ext >= w_bottom_ext) && (w_y_ext < w_bottom_ext);

   assign busy       = (state_q != IDLE);
   assign ObjectOn   = busy & w_x_in & w_y_in;
   assign TileBottom = tile_bottom_q;
   assign hit        = hit_q;
   assign miss       = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_lane_ctrl.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
//  Module   : tb_tile_lane_ctrl
//  Purpose  : Directed, table-driven bench for tile_lane_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tile_lane_ctrl;

   logic        Clk;
   logic        Reset;
   logic        frame_clk;
   logic        start;
   logic        key_press;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        ObjectOn;
   logic [10:0] TileBottom;
   logic        hit;
   logic        miss;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int cur      = 0;   // expected TileBottom while falling

   typedef struct {
      int          bottom;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        exp_on;
   } vec_t;

   vec_t vecs[14];

   tile_lane_ctrl dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .start      (start),
      .key_press  (key_press),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .ObjectOn   (ObjectOn),
      .TileBottom (TileBottom),
      .hit        (hit),
      .miss       (miss),
      .busy       (busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic tick();
      frame_clk = 1'b1;
      step();
      frame_clk = 1'b0;
      step();
   endtask

   task automatic fall_to(input int target);
      while (cur < target) begin
         tick();
         cur += 2;
      end
   endtask

   task automatic launch();
      start = 1'b1;
      step();
      start = 1'b0;
      cur = 0;
   endtask

   initial begin
      int bad;
      vecs[0]  = '{80,  10'd0,    10'd79,   1'b1};
      vecs[1]  = '{80,  10'd0,    10'd80,   1'b0};
      vecs[2]  = '{80,  10'd100,  10'd79,   1'b0};
      vecs[3]  = '{80,  10'd99,   10'd79,   1'b1};
      vecs[4]  = '{80,  10'd0,    10'd0,    1'b1};
      vecs[5]  = '{80,  10'd50,   10'd40,   1'b1};
      vecs[6]  = '{80,  10'd1023, 10'd10,   1'b0};
      vecs[7]  = '{80,  10'd0,    10'd1023, 1'b0};
      vecs[8]  = '{200, 10'd0,    10'd99,   1'b0};
      vecs[9]  = '{200, 10'd0,    10'd100,  1'b1};
      vecs[10] = '{200, 10'd0,    10'd199,  1'b1};
      vecs[11] = '{200, 10'd0,    10'd200,  1'b0};
      vecs[12] = '{200, 10'd99,   10'd150,  1'b1};
      vecs[13] = '{200, 10'd100,  10'd150,  1'b0};

      Reset = 1'b1; frame_clk = 1'b0; start = 1'b0; key_press = 1'b0;
      DrawX = 10'd0; DrawY = 10'd0;
      step(); step();
      Reset = 1'b0;
      step();
      check("reset_busy",   busy,       0);
      check("reset_bottom", TileBottom, 0);
      check("reset_obj",    ObjectOn,   0);
      check("reset_hit",    hit,        0);
      check("reset_miss",   miss,       0);

      // Reset held three cycles mid-fall
      launch();
      fall_to(10);
      check("midfall_bottom", TileBottom, 10);
      Reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (miss) bad++;
      end
      Reset = 1'b0;
      step();
      if (miss) bad++;
      DrawY = 10'd5;
      #0.01;
      check("rst_abort_nomiss", bad,        0);
      check("rst_abort_bottom", TileBottom, 0);
      check("rst_abort_busy",   busy,       0);
      check("rst_abort_obj",    ObjectOn,   0);

      // Table-driven box checks while falling
      launch();
      check("launch_busy", busy, 1);
      for (int i = 0; i < 14; i++) begin
         fall_to(vecs[i].bottom);
         DrawX = vecs[i].x;
         DrawY = vecs[i].y;
         #0.01;
         check($sformatf("vec%0d_bottom", i), TileBottom, vecs[i].bottom);
         check($sformatf("vec%0d_obj", i),    ObjectOn,   vecs[i].exp_on);
      end

      // start while falling is ignored
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_in_fall", TileBottom, 200);

      // Hit at 380, then eight-frame flash
      fall_to(380);
      key_press = 1'b1;
      step();
      check("hit_pulse",  hit,  1);
      check("hit_nomiss", miss, 0);
      key_press = 1'b0;
      step();
      check("hit_width",  hit,  0);
      check("flash_busy", busy, 1);
      key_press = 1'b1;
      step();
      key_press = 1'b0;
      step();
      check("flash_key_ignored", hit | miss, 0);
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (!busy || TileBottom != 11'd380) bad++;
      end
      check("flash_frozen", bad, 0);
      tick();
      check("flash_end_busy",   busy,       0);
      check("flash_end_bottom", TileBottom, 0);

      // Early press at 378 -> miss
      launch();
      fall_to(378);
      key_press = 1'b1;
      step();
      check("early_miss",  miss, 1);
      check("early_nohit", hit,  0);
      check("early_idle",  busy, 0);
      key_press = 1'b0;
      step();
      check("early_miss_width", miss, 0);
      key_press = 1'b1;
      step();
      bad = (hit | miss) ? 1 : 0;
      key_press = 1'b0;
      step();
      if (hit | miss) bad++;
      check("idle_key_ignored", bad, 0);

      // Escape without a press
      launch();
      fall_to(578);
      check("esc_578_busy", busy, 1);
      check("esc_578_miss", miss, 0);
      frame_clk = 1'b1;
      step();
      frame_clk = 1'b0;
      cur = 580;
      check("esc_580_bottom", TileBottom, 580);
      bad = 0;
      DrawX = 10'd0;
      for (int y = 0; y < 480; y++) begin
         DrawY = 10'(y);
         #0.01;
         if (ObjectOn) bad++;
      end
      check("esc_obj_off", bad, 0);
      step();
      check("esc_miss", miss, 1);
      check("esc_idle", busy, 0);
      step();
      check("esc_miss_width", miss, 0);

      // Key edge and tick together at 378 -> miss, no move
      launch();
      fall_to(376);
      frame_clk = 1'b1;
      step();
      frame_clk = 1'b0;
      step();
      check("sim_pre_378", TileBottom, 378);
      frame_clk = 1'b1;
      key_press = 1'b1;
      step();
      check("sim378_miss",   miss,       1);
      check("sim378_bottom", TileBottom, 378);
      frame_clk = 1'b0;
      key_press = 1'b0;
      step();

      // Key edge and tick together at 380 -> hit, no move
      launch();
      fall_to(380);
      frame_clk = 1'b1;
      key_press = 1'b1;
      step();
      check("sim380_hit",    hit,        1);
      check("sim380_bottom", TileBottom, 380);
      frame_clk = 1'b0;
      key_press = 1'b0;
      step();
      for (int i = 0; i < 7; i++) tick();
      check("sim380_flash_busy", busy, 1);
      tick();
      check("sim380_flash_done", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
